// File: rtl/sa_mem_pkg.sv
// Shared definitions for the systolic-array result writeback path:
// schedule entry encoding and writeback FSM states.
package sa_mem_pkg;

  localparam logic [7:0] LOC_SKIP = 8'hFF;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DONE
  } wb_state_t;

endpackage

// File: rtl/sa_loc_table.sv
// Schedule RAM: one write port, one registered read port whose enable lets the
// writeback engine freeze the prefetched entry during a memory stall.
module sa_loc_table #(
  parameter int DEPTH = 45,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_L)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // A write and read of the same entry on one edge returns the new data, so a
  // table update issued alongside start is seen by the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      if (we && (waddr == raddr)) begin
        rdata_q <= wdata;
      end else if ({1'b0, raddr} < DEPTH_L) begin
        rdata_q <= mem_q[raddr];
      end else begin
        rdata_q <= '0;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sa_result_writeback.sv
// Drains NCH systolic-array output channels into result memory, walking a
// programmable {row,col} schedule one step per cycle with round-robin channels.
module sa_result_writeback
  import sa_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NCH        = 5,
  parameter int ADDR_W     = 8,
  parameter int LOC_DEPTH  = 45,
  parameter int LOC_AW     = 6,
  parameter int ROW_STRIDE = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [NCH*DATA_W-1:0] ch_data,
  input  logic                  loc_we,
  input  logic [LOC_AW-1:0]     loc_waddr,
  input  logic [7:0]            loc_wdata,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic [LOC_AW:0]       wr_count
);

  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SUM_W = ADDR_W + 4;
  localparam logic [LOC_AW-1:0] LAST_STEP = LOC_AW'(LOC_DEPTH - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NCH - 1);

  wb_state_t         state_q, state_d;
  logic [LOC_AW-1:0] step_q, step_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LOC_AW:0]   wr_count_q, wr_count_d;
  logic              last_q, last_d;

  logic              tbl_we, tbl_re, ld;
  logic [LOC_AW-1:0] tbl_raddr;
  logic [7:0]        tbl_rdata;
  logic [ROW_W-1:0]  ent_row;
  logic [COL_W-1:0]  ent_col;
  logic [ADDR_W-1:0] addr_calc;
  logic [DATA_W-1:0] ch_word;

  assign tbl_we = loc_we && (state_q == IDLE);

  sa_loc_table #(
    .DEPTH (LOC_DEPTH),
    .AW    (LOC_AW)
  ) u_loc_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tbl_we),
    .waddr (loc_waddr),
    .wdata (loc_wdata),
    .re    (tbl_re),
    .raddr (tbl_raddr),
    .rdata (tbl_rdata)
  );

  assign ent_row   = tbl_rdata[7:4];
  assign ent_col   = tbl_rdata[3:0];
  assign addr_calc = ADDR_W'(SUM_W'(base_q) + SUM_W'(ent_row) * SUM_W'(ROW_STRIDE)
                             + SUM_W'(ent_col));

  always_comb begin
    ch_word = '0;
    for (int c = 0; c < NCH; c++) begin
      if (chan_q == CH_W'(c)) ch_word = ch_data[c*DATA_W +: DATA_W];
    end
  end

  // The table read runs one entry ahead of the presented step: entry 0 is read
  // on the start edge, so PRIME can register step 0 and fetch entry 1.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    chan_d      = chan_q;
    base_d      = base_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_count_d  = wr_count_q;
    last_d      = last_q;
    tbl_re      = 1'b0;
    tbl_raddr   = step_q + 1'b1;
    ld          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = PRIME;
          base_d     = base_addr;
          wr_count_d = '0;
          step_d     = '0;
          chan_d     = '0;
          tbl_re     = 1'b1;
          tbl_raddr  = '0;
        end
      end
      PRIME: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          ld      = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d  = IDLE;
          mem_we_d = 1'b0;
        end else if (!mem_we_q || mem_ready) begin
          if (mem_we_q) wr_count_d = wr_count_q + 1'b1;
          if (last_q) begin
            state_d  = DONE;
            mem_we_d = 1'b0;
          end else begin
            ld = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (ld) begin
      tbl_re      = 1'b1;
      mem_we_d    = (tbl_rdata != LOC_SKIP);
      mem_addr_d  = addr_calc;
      mem_wdata_d = ch_word;
      chan_d      = (chan_q == LAST_CH) ? '0 : chan_q + 1'b1;
      last_d      = (step_q == LAST_STEP);
      step_d      = step_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      chan_q      <= '0;
      base_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_count_q  <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      chan_q      <= chan_d;
      base_q      <= base_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_count_q  <= wr_count_d;
      last_q      <= last_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_count  = wr_count_q;
  assign busy      = (state_q == PRIME) || (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_sa_result_writeback.sv
// Scoreboard bench for sa_result_writeback: expected writes are queued at start
// and matched against accepted memory writes.
module tb_sa_result_writeback;

  localparam int DATA_W     = 32;
  localparam int NCH        = 5;
  localparam int ADDR_W     = 8;
  localparam int LOC_DEPTH  = 45;
  localparam int LOC_AW     = 6;
  localparam int ROW_STRIDE = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  abort;
  logic [ADDR_W-1:0]     base_addr;
  logic [NCH*DATA_W-1:0] ch_data;
  logic                  loc_we;
  logic [LOC_AW-1:0]     loc_waddr;
  logic [7:0]            loc_wdata;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ready;
  logic                  busy;
  logic                  done;
  logic [LOC_AW:0]       wr_count;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  tbl_m [LOC_DEPTH];
  logic [31:0] ch_seed;
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;

  sa_result_writeback #(
    .DATA_W(DATA_W), .NCH(NCH), .ADDR_W(ADDR_W),
    .LOC_DEPTH(LOC_DEPTH), .LOC_AW(LOC_AW), .ROW_STRIDE(ROW_STRIDE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .ch_data(ch_data),
    .loc_we(loc_we), .loc_waddr(loc_waddr), .loc_wdata(loc_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] chval(input int c);
    return ch_seed + 32'(c) * 32'h0000_1111;
  endfunction

  task automatic set_ch();
    for (int c = 0; c < NCH; c++) ch_data[c*DATA_W +: DATA_W] = chval(c);
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] b);
    for (int k = 0; k < LOC_DEPTH; k++) begin
      logic [7:0] e;
      int         s;
      exp_t       x;
      e = tbl_m[k];
      if (e != 8'hFF) begin
        s = int'(b) + int'(e[7:4]) * ROW_STRIDE + int'(e[3:0]);
        x.a = s[ADDR_W-1:0];
        x.d = chval(k % NCH);
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic wr_ent(input int a, input logic [7:0] d);
    @(posedge clk); #1;
    loc_we = 1'b1; loc_waddr = LOC_AW'(a); loc_wdata = d; tbl_m[a] = d;
    @(posedge clk); #1;
    loc_we = 1'b0;
  endtask

  task automatic load_ident();
    for (int k = 0; k < LOC_DEPTH; k++) begin
      @(posedge clk); #1;
      loc_we = 1'b1; loc_waddr = LOC_AW'(k);
      loc_wdata = {4'(k / 5), 4'(k % 5)};
      tbl_m[k] = loc_wdata;
    end
    @(posedge clk); #1;
    loc_we = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] b, input logic [31:0] seed, input bit wr,
                           input int wa, input logic [7:0] wd, output int t);
    @(posedge clk); #1;
    ch_seed = seed;
    set_ch();
    if (wr) begin
      loc_we = 1'b1; loc_waddr = LOC_AW'(wa); loc_wdata = wd; tbl_m[wa] = wd;
    end
    start = 1'b1; base_addr = b; t = cyc;
    push_exp(b);
    @(posedge clk); #1;
    start = 1'b0; loc_we = 1'b0;
  endtask

  task automatic wait_done(input int t, input int lat, input int exp_wr);
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 64'(seen), 64'd1);
    else       chk("done_latency", 64'(cyc - t), 64'(lat));
    chk("wr_count", 64'(wr_count), 64'(exp_wr));
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  // Accepted-write monitor; abort overrides a same-cycle handshake.
  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ready && !abort) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t x;
        x = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(x.a));
        chk("wr_data", 64'(mem_wdata), 64'(x.d));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    bit seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; ch_data = '0;
    loc_we = 1'b0; loc_waddr = '0; loc_wdata = '0; mem_ready = 1'b1; ch_seed = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);

    // Identity schedule, latency of the first step and of done
    load_ident();
    start_run(8'h10, 32'hA000_0000, 1'b0, 0, 8'h00, t);
    @(negedge clk);
    chk("prime_busy", 64'(busy), 64'd1);
    chk("prime_we", 64'(mem_we), 64'd0);
    @(negedge clk);
    chk("step0_latency", 64'(cyc - t), 64'd2);
    chk("step0_we", 64'(mem_we), 64'd1);
    chk("step0_addr", 64'(mem_addr), 64'h10);
    wait_done(t, 47, 45);

    // Skip entries
    wr_ent(3, 8'hFF);
    wr_ent(7, 8'hFF);
    start_run(8'h10, 32'hB000_0000, 1'b0, 0, 8'h00, t);
    wait_done(t, 47, 43);
    wr_ent(3, 8'h03);
    wr_ent(7, 8'h12);

    // Four stall cycles at step 10 with channel data churning
    start_run(8'h10, 32'hC000_0000, 1'b0, 0, 8'h00, t);
    repeat (11) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < NCH; c++) ch_data[c*DATA_W +: DATA_W] = $urandom();
      @(negedge clk);
      chk("stall_we", 64'(mem_we), 64'd1);
      chk("stall_addr", 64'(mem_addr), 64'h1A);
      chk("stall_data", 64'(mem_wdata), 64'(chval(0)));
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    set_ch();
    wait_done(t, 51, 45);

    // Address wrap-around
    wr_ent(0, 8'h42);
    start_run(8'hF0, 32'hD000_0000, 1'b0, 0, 8'h00, t);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_addr", 64'(mem_addr), 64'h06);
    wait_done(t, 47, 45);
    wr_ent(0, 8'h00);

    // Abort at step 20, then a clean run
    start_run(8'h10, 32'hE000_0000, 1'b0, 0, 8'h00, t);
    repeat (21) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_we", 64'(mem_we), 64'd0);
    chk("abort_wr_count", 64'(wr_count), 64'd20);
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (done) seen = 1'b1; end
    chk("abort_no_done", 64'(seen), 64'd0);
    exp_q.delete();
    start_run(8'h10, 32'hF000_0000, 1'b0, 0, 8'h00, t);
    wait_done(t, 47, 45);

    // start and loc_we while busy are dropped; async reset mid-run
    start_run(8'h10, 32'h1234_0000, 1'b0, 0, 8'h00, t);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; base_addr = 8'h80;
    loc_we = 1'b1; loc_waddr = 6'd5; loc_wdata = 8'h77;
    @(posedge clk); #1;
    start = 1'b0; loc_we = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", 64'(mem_we), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_wr_count", 64'(wr_count), 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    chk("midrst_wdata", 64'(mem_wdata), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table survives reset; a write alongside start is seen by that run
    start_run(8'h20, 32'h5555_0000, 1'b1, 0, 8'h11, t);
    wait_done(t, 47, 45);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
